seg7_capture: RTL and testbench

//  Receive-side counterpart of the multiplexed 7-segment driver. Snoops the LED[7:0]/SA[3:0] scan bus,

---
 rtl/seg7_capture.sv | 213 +++++++++++++++++++++
 tb/tb_seg7_capture.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_capture.sv
// seg7_capture
//   Snoops a multiplexed 7-segment scan bus (LED segments + SA digit
//   selects), waits until each digit's pattern has been steady for
//   STABLE_CYC cycles, decodes the glyph back to a hex nibble and, once all
//   four digits have been seen, publishes the frame with a VALID/ACK
//   handshake.
//
//   Ports
//     CLK    in   1   clock, rising edge
//     RST    in   1   synchronous reset, active-high
//     LED    in   8   segments [0]a..[6]g, [7]dp
//     SA     in   4   digit select, one-hot after polarity fix
//     ACK    in   1   consumer took the frame (only while VALID=1)
//     FRAME  out 16   digit n at FRAME[4n+3:4n]
//     DP     out  4   decimal point per digit
//     ERR    out  4   per-digit illegal-glyph flag
//     VALID  out  1   frame available, held until ACK
//     OVF    out  1   sticky: frame completed while VALID=1 and ACK=0
//
//   Parameters
//     STABLE_CYC   1..255 identical cycles before a digit is accepted
//     SEG_ACT_LOW  1: LED is active-low
//     SA_ACT_LOW   1: SA is active-low
//
//   Build option
//     SEG7CAP_ALT_GLYPH_EN  also accept alternate glyphs 0x27 -> 7, 0x67 -> 9
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | no digit selected (blank / multi-hot select)
//   SETTLE  | counting identical cycles of the reference select+pattern
//   CAPTURE | one cycle: write the shadow digit, mark it seen
//   HOLD    | digit captured, waiting for the bus to move on

module seg7_capture #(
  parameter int unsigned STABLE_CYC  = 4,
  parameter bit          SEG_ACT_LOW = 1'b0,
  parameter bit          SA_ACT_LOW  = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  LED,
  input  logic [3:0]  SA,
  input  logic        ACK,
  output logic [15:0] FRAME,
  output logic [3:0]  DP,
  output logic [3:0]  ERR,
  output logic        VALID,
  output logic        OVF
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETTLE  = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] HOLD    = 2'd3;

  localparam logic [7:0] STABLE_N = 8'(STABLE_CYC);

  // A fresh run already satisfies the count when only one cycle is needed.
  localparam logic [1:0] RUN_START = (STABLE_N == 8'd1) ? CAPTURE : SETTLE;

  // {err, hex}
  function automatic logic [4:0] glyph_decode(input logic [6:0] g);
    logic [4:0] r;
    case (g)
      7'h3F:   r = 5'h00;
      7'h06:   r = 5'h01;
      7'h5B:   r = 5'h02;
      7'h4F:   r = 5'h03;
      7'h66:   r = 5'h04;
      7'h6D:   r = 5'h05;
      7'h7D:   r = 5'h06;
      7'h07:   r = 5'h07;
      7'h7F:   r = 5'h08;
      7'h6F:   r = 5'h09;
      7'h77:   r = 5'h0A;
      7'h7C:   r = 5'h0B;
      7'h39:   r = 5'h0C;
      7'h5E:   r = 5'h0D;
      7'h79:   r = 5'h0E;
      7'h71:   r = 5'h0F;
`ifdef SEG7CAP_ALT_GLYPH_EN
      7'h27:   r = 5'h07;
      7'h67:   r = 5'h09;
`endif
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] r;
    case (v)
      4'b0010: r = 2'd1;
      4'b0100: r = 2'd2;
      4'b1000: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  logic [7:0]  s;
  logic [3:0]  d;
  logic        d_onehot;
  logic        changed;

  logic [1:0]  state;
  logic [7:0]  cnt;
  logic [3:0]  ref_d;
  logic [7:0]  ref_s;
  logic [3:0]  seen;
  logic [15:0] sh_frame;
  logic [3:0]  sh_dp;
  logic [3:0]  sh_err;
  logic        pub_pend;

  logic [4:0]  dec;
  logic [1:0]  cap_idx;
  logic [3:0]  cap_bit;

  always_comb begin
    s        = SEG_ACT_LOW ? ~LED : LED;
    d        = SA_ACT_LOW  ? ~SA  : SA;
    d_onehot = (d != 4'd0) && ((d & (d - 4'd1)) == 4'd0);
    changed  = (d != ref_d) || (s != ref_s);
    dec      = glyph_decode(ref_s[6:0]);
    cap_idx  = onehot_idx(ref_d);
    cap_bit  = 4'b0001 << cap_idx;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      ref_d    <= 4'd0;
      ref_s    <= 8'd0;
      seen     <= 4'd0;
      sh_frame <= 16'd0;
      sh_dp    <= 4'd0;
      sh_err   <= 4'd0;
      pub_pend <= 1'b0;
      FRAME    <= 16'd0;
      DP       <= 4'd0;
      ERR      <= 4'd0;
      VALID    <= 1'b0;
      OVF      <= 1'b0;
    end else begin
      pub_pend <= 1'b0;

      // Publishing wins over ACK: the consumer acked the old frame, the new
      // one is immediately available.
      if (pub_pend) begin
        FRAME <= sh_frame;
        DP    <= sh_dp;
        ERR   <= sh_err;
        VALID <= 1'b1;
        seen  <= 4'd0;
        if (VALID && !ACK) OVF <= 1'b1;
      end else if (VALID && ACK) begin
        VALID <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (d_onehot) begin
            ref_d <= d;
            ref_s <= s;
            cnt   <= 8'd1;
            state <= RUN_START;
          end
        end
        SETTLE: begin
          if (changed) begin
            ref_d <= d;
            ref_s <= s;
            if (d_onehot) begin
              cnt   <= 8'd1;
              state <= RUN_START;
            end else begin
              cnt   <= 8'd0;
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 8'd1;
            if (cnt + 8'd1 == STABLE_N) state <= CAPTURE;
          end
        end
        CAPTURE: begin
          sh_frame[{cap_idx, 2'b00} +: 4] <= dec[3:0];
          sh_dp[cap_idx]                  <= ref_s[7];
          sh_err[cap_idx]                 <= dec[4];
          seen                            <= seen | cap_bit;
          if ((seen | cap_bit) == 4'b1111) pub_pend <= 1'b1;
          state <= HOLD;
        end
        default: begin // HOLD
          if (changed) begin
            ref_d <= d;
            ref_s <= s;
            if (d_onehot) begin
              cnt   <= 8'd1;
              state <= RUN_START;
            end else begin
              cnt   <= 8'd0;
              state <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
module tb_seg7_capture;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ack;
  logic [3:0]  cur_d;
  logic [7:0]  cur_s;

  logic [7:0]  led_a, led_b;
  logic [3:0]  sa_a, sa_b;
  assign led_a = cur_s;
  assign sa_a  = cur_d;
  assign led_b = ~cur_s;
  assign sa_b  = ~cur_d;

  logic [15:0] fr_a, fr_b, fr_c;
  logic [3:0]  dp_a, dp_b, dp_c, er_a, er_b, er_c;
  logic        va_a, va_b, va_c, ov_a, ov_b, ov_c;

  seg7_capture #(.STABLE_CYC(4), .SEG_ACT_LOW(1'b0), .SA_ACT_LOW(1'b0)) dut_a (
    .CLK(clk), .RST(rst), .LED(led_a), .SA(sa_a), .ACK(ack),
    .FRAME(fr_a), .DP(dp_a), .ERR(er_a), .VALID(va_a), .OVF(ov_a));

  seg7_capture #(.STABLE_CYC(4), .SEG_ACT_LOW(1'b1), .SA_ACT_LOW(1'b1)) dut_b (
    .CLK(clk), .RST(rst), .LED(led_b), .SA(sa_b), .ACK(ack),
    .FRAME(fr_b), .DP(dp_b), .ERR(er_b), .VALID(va_b), .OVF(ov_b));

  seg7_capture #(.STABLE_CYC(1), .SEG_ACT_LOW(1'b0), .SA_ACT_LOW(1'b0)) dut_c (
    .CLK(clk), .RST(rst), .LED(led_a), .SA(sa_a), .ACK(ack),
    .FRAME(fr_c), .DP(dp_c), .ERR(er_c), .VALID(va_c), .OVF(ov_c));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Model 0 is STABLE_CYC=4 (dut_a, dut_b), model 1 is STABLE_CYC=1 (dut_c).
  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int          n_of [2] = '{4, 1};
  logic [3:0]  m_rd [2];
  logic [7:0]  m_rs [2];
  int          m_len [2];
  bit          m_cap [2];
  bit          m_pub [2];
  logic [3:0]  m_seen [2];
  logic [15:0] m_shf [2];
  logic [3:0]  m_shd [2];
  logic [3:0]  m_she [2];
  logic [15:0] m_fr [2];
  logic [3:0]  m_dp [2];
  logic [3:0]  m_er [2];
  bit          m_va [2];
  bit          m_ov [2];

  function automatic logic [4:0] ref_decode(input logic [6:0] g);
    for (int i = 0; i < 16; i++)
      if (glyph_tab[i] == g) return {1'b0, 4'(i)};
`ifdef SEG7CAP_ALT_GLYPH_EN
    if (g == 7'h27) return 5'h07;
    if (g == 7'h67) return 5'h09;
`endif
    return 5'h10;
  endfunction

  // A run is a stretch of identical (select, pattern) samples. A one-hot run
  // is captured once its length reaches N; the sample taken while capturing
  // is not looked at, and publishing follows the capture by one cycle.
  task automatic model_step(input int m);
    int n;
    int idx;
    logic [4:0] dv;
    bit oh;
    n = n_of[m];
    if (rst) begin
      m_rd[m] = '0; m_rs[m] = '0; m_len[m] = 0; m_cap[m] = 0; m_pub[m] = 0;
      m_seen[m] = '0; m_shf[m] = '0; m_shd[m] = '0; m_she[m] = '0;
      m_fr[m] = '0; m_dp[m] = '0; m_er[m] = '0; m_va[m] = 0; m_ov[m] = 0;
      return;
    end
    if (m_pub[m]) begin
      if (m_va[m] && !ack) m_ov[m] = 1;
      m_va[m] = 1;
      m_fr[m] = m_shf[m]; m_dp[m] = m_shd[m]; m_er[m] = m_she[m];
      m_pub[m] = 0;
      m_seen[m] = '0;
    end else if (m_va[m] && ack) begin
      m_va[m] = 0;
    end
    oh = ($countones(cur_d) == 1);
    if (m_cap[m]) begin
      idx = 0;
      for (int k = 0; k < 4; k++) if (m_rd[m][k]) idx = k;
      dv = ref_decode(m_rs[m][6:0]);
      m_shf[m][idx*4 +: 4] = dv[3:0];
      m_shd[m][idx] = m_rs[m][7];
      m_she[m][idx] = dv[4];
      m_seen[m][idx] = 1'b1;
      if (m_seen[m] == 4'hF) m_pub[m] = 1;
      m_cap[m] = 0;
    end else if (cur_d == m_rd[m] && cur_s == m_rs[m]) begin
      if (oh && m_len[m] <= n) begin
        m_len[m]++;
        if (m_len[m] == n) m_cap[m] = 1;
      end
    end else begin
      m_rd[m] = cur_d;
      m_rs[m] = cur_s;
      m_len[m] = oh ? 1 : 0;
      if (m_len[m] == n) m_cap[m] = 1;
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_a", {6'd0, fr_a, dp_a, er_a, va_a, ov_a}, {6'd0, m_fr[0], m_dp[0], m_er[0], m_va[0], m_ov[0]});
      chk("cyc_b", {6'd0, fr_b, dp_b, er_b, va_b, ov_b}, {6'd0, m_fr[0], m_dp[0], m_er[0], m_va[0], m_ov[0]});
      chk("cyc_c", {6'd0, fr_c, dp_c, er_c, va_c, ov_c}, {6'd0, m_fr[1], m_dp[1], m_er[1], m_va[1], m_ov[1]});
    end
  end

  // ---------------- stimulus ----------------
  task automatic show(input logic [3:0] d, input logic [7:0] s, input int n);
    cur_d = d;
    cur_s = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    show(4'd0, 8'd0, 2);
    rst = 1'b0;
  endtask

  task automatic scan4(input logic [7:0] g0, input logic [7:0] g1,
                       input logic [7:0] g2, input logic [7:0] g3);
    show(4'b0001, g0, 6);
    show(4'b0010, g1, 6);
    show(4'b0100, g2, 6);
    show(4'b1000, g3, 6);
  endtask

  task automatic take();
    ack = 1'b1;
    show(4'd0, 8'd0, 1);
    ack = 1'b0;
  endtask

  // Literal expectations on both STABLE_CYC=4 instances.
  task automatic lit(input string nm, input logic [15:0] fr, input logic [3:0] dp,
                     input logic [3:0] er, input logic va, input logic ov);
    chk({nm, "_a"}, {6'd0, fr_a, dp_a, er_a, va_a, ov_a}, {6'd0, fr, dp, er, va, ov});
    chk({nm, "_b"}, {6'd0, fr_b, dp_b, er_b, va_b, ov_b}, {6'd0, fr, dp, er, va, ov});
  endtask

  initial begin
    logic [3:0] d;
    logic [7:0] s;
    int n;
    rst = 1'b1; ack = 1'b0; cur_d = '0; cur_s = '0;
    do_reset();
    chk_en = 1;
    lit("reset", 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0);

    // "1234": digit3..0 = 1,2,3,4
    scan4(8'h66, 8'h4F, 8'h5B, 8'h06);
    lit("frame_1234", 16'h1234, 4'h0, 4'h0, 1'b1, 1'b0);
    take();
    lit("ack_clears", 16'h1234, 4'h0, 4'h0, 1'b0, 1'b0);

    // Short glitch of 3F must not be captured.
    show(4'b0001, 8'h3F, 2);
    show(4'b0001, 8'h06, 6);
    show(4'b0010, 8'h5B, 6);
    show(4'b0100, 8'h7F, 6);
    show(4'b1000, 8'h6D, 6);
    lit("glitch", 16'h5821, 4'h0, 4'h0, 1'b1, 1'b0);
    take();

    // Illegal 0x49 on digit 2, dp on digit 1.
    scan4(8'h06, 8'hDB, 8'h49, 8'h3F);
    lit("illegal_dp", 16'h0021, 4'b0010, 4'b0100, 1'b1, 1'b0);
    take();

    // Overflow: two frames without ACK.
    scan4(8'h66, 8'h4F, 8'h5B, 8'h06);
    scan4(8'h77, 8'h7C, 8'h39, 8'h5E);
    lit("overflow", 16'hDCBA, 4'h0, 4'h0, 1'b1, 1'b1);

    // ACK exactly at the completion edge: VALID stays, no overflow.
    do_reset();
    lit("reset2", 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0);
    scan4(8'h66, 8'h4F, 8'h5B, 8'h06);
    show(4'b0001, 8'h77, 6);
    show(4'b0010, 8'h7C, 6);
    show(4'b0100, 8'h39, 6);
    show(4'b1000, 8'h5E, 5);
    ack = 1'b1;
    show(4'b1000, 8'h5E, 1);
    ack = 1'b0;
    lit("ack_at_done", 16'hDCBA, 4'h0, 4'h0, 1'b1, 1'b0);
    take();

    // Blank / multi-hot selects never capture.
    show(4'b0011, 8'h3F, 20);
    show(4'b0000, 8'h3F, 20);
    show(4'b0001, 8'h3F, 6);
    show(4'b0010, 8'h06, 6);
    show(4'b0100, 8'h5B, 6);
    lit("blank", 16'hDCBA, 4'h0, 4'h0, 1'b0, 1'b0);

    // Reset mid-scan drops the partial digits.
    do_reset();
    show(4'b0001, 8'h3F, 6);
    show(4'b0010, 8'h06, 6);
    do_reset();
    show(4'b0100, 8'h5B, 6);
    show(4'b1000, 8'h4F, 6);
    lit("rst_partial", 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0);
    show(4'b0001, 8'h66, 6);
    show(4'b0010, 8'h6D, 6);
    lit("post_rst", 16'h3254, 4'h0, 4'h0, 1'b1, 1'b0);
    take();

    // Alternate glyph 0x27 on digit 0.
    scan4(8'h27, 8'h06, 8'h06, 8'h06);
`ifdef SEG7CAP_ALT_GLYPH_EN
    lit("alt27", 16'h1117, 4'h0, 4'h0, 1'b1, 1'b0);
`else
    lit("alt27", 16'h1110, 4'h0, 4'h1, 1'b1, 1'b0);
`endif
    take();

    // Randomized scanning with random ACK and occasional reset.
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 9))
        0:       d = 4'd0;
        1:       d = 4'($urandom_range(0, 15));
        default: d = 4'b0001 << $urandom_range(0, 3);
      endcase
      if ($urandom_range(0, 4) != 0) s = {1'($urandom_range(0, 1)), glyph_tab[$urandom_range(0, 15)]};
      else                           s = 8'($urandom_range(0, 255));
      n = $urandom_range(1, 8);
      rst = ($urandom_range(0, 99) == 0);
      for (int c = 0; c < n; c++) begin
        ack = ($urandom_range(0, 3) == 0);
        show(d, s, 1);
        rst = 1'b0;
      end
    end
    ack = 1'b0;
    show(4'd0, 8'd0, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
